cpu_issue_arbiter: RTL and testbench
====================================

# cpu_issue_arbiter

Shares one `cpu` instance between two instruction requesters. It accepts one 16-bit instruction at a time from either requester, with round-robin priority. It issues the instruction to the cpu through the `in`/`load`/`s` inputs and tracks completion on `w`, then returns `out` and the N/V/Z flags to the requester that issued it. The block sits between the two instruction sources and the cpu's top-level ports, and nothing else drives the cpu.

## Interface
- `TIMEOUT`, default 64: maximum cycles allowed in WAIT_START plus WAIT_DONE before the block aborts with an error; range 2..255.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid` / `req1_valid` in 1: requester has an instruction pending.
- `req0_instr` / `req1_instr` in 16: instruction word; must be stable while valid.
- `req0_ready` / `req1_ready` out 1: one-cycle accept pulse; the instruction is taken on this cycle.
- `rsp0_valid` / `rsp1_valid` out 1: one-cycle response pulse to the owning requester; there is no backpressure.
- `rsp_data` out 16: shared response bus, carrying the cpu `out` value captured at completion.
- `rsp_flags` out 3: shared response bus, carrying {N,V,Z} captured at completion.
- `rsp_err` out 1: response is a timeout abort.
- `busy` out 1: high in every state except IDLE.
- `cpu_in` out 16: instruction to the cpu.
- `cpu_load` out 1: cpu instruction-register load.
- `cpu_s` out 1: cpu start.
- `cpu_out` in 16: cpu result.
- `cpu_N`, `cpu_V`, `cpu_Z` in 1 each: cpu status flags.
- `cpu_w` in 1: cpu waiting/idle.

## Operation
- FSM states: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- **IDLE**
  - If any `reqN_valid` is high and `cpu_w`=1, grant one requester and pulse its `reqN_ready` in the same cycle (combinational).
  - Register the instruction and an `owner` bit, then go to ISSUE.
  - If `cpu_w`=0, grant nobody.
- **Round-robin**
  - A `last` register records the previous owner.
  - When both requesters are valid, the grant goes to the requester other than `last`.
  - When one requester is valid, it always wins.
  - `last` updates on every grant.
- **ISSUE** (exactly one cycle)
  - `cpu_load`=`cpu_s`=1 and `cpu_in` = the captured instruction.
  - Next state is WAIT_START.
- **WAIT_START**
  - Wait for `cpu_w`=0, then go to WAIT_DONE.
- **WAIT_DONE**
  - Wait for `cpu_w`=1.
  - In that same cycle, capture `cpu_out` into `rsp_data` and {`cpu_N`,`cpu_V`,`cpu_Z`} into `rsp_flags`, clear `rsp_err`, and go to RESP.
- **Watchdog**
  - An 8-bit counter clears on entry to WAIT_START and increments each cycle in WAIT_START and WAIT_DONE.
  - When it reaches `TIMEOUT-1` without completion, go to RESP with `rsp_err`=1 and `rsp_data`=0; `rsp_flags` holds its last value.
- **RESP** (one cycle)
  - `rspN_valid`=1 for the owner only.
  - Next state is IDLE.
- `cpu_in` holds the captured instruction from ISSUE through RESP. In IDLE it holds its last value, so the cpu sees no spurious changes.
- `cpu_load` and `cpu_s` are 0 in every state except ISSUE.
- `rsp_data`, `rsp_flags` and `rsp_err` remain stable until the next capture.

## Timing
- **Reset values:**
  - State: IDLE.
  - `last`: 1, so req0 wins the first tie.
  - All `ready`/`rsp_valid` signals, `cpu_load`, `cpu_s` and `busy` at 0.
  - `cpu_in`, `rsp_data`, `rsp_flags` and `rsp_err` all at 0.
- **Reset mid-operation:**
  - The next cycle is IDLE with the reset values.
  - The in-flight request receives no response.
  - The cpu is not re-driven until `cpu_w`=1.
- **Latency:**
  - Accept at cycle A; ISSUE at A+1; cpu busy from A+2.
  - RESP at D+1, where D is the cycle in which `cpu_w` returns to 1.
  - The next accept can happen at D+2 at the earliest.
- Only one instruction is in flight; no request is accepted outside IDLE.
- A `reqN_valid` that drops before it is accepted is simply not served.
- A requester whose valid stays high across its own RESP cycle is re-arbitrated in IDLE like any other.
- **Starvation:** with both valids held high, grants strictly alternate 0,1,0,1.
- **Simultaneous events:** `cpu_w` rising in the same cycle the counter hits `TIMEOUT-1` is a normal completion (`rsp_err`=0).

## Test plan
- **Basic sequence:**
  - Stimulus, in order: req0 0xD007 (MOV R0,#7); req1 0xD102 (MOV R1,#2); req0 0xA148 (ADD R2,R1,R0,LSL#1).
  - Required: three responses in order, with owners 0,1,0; the third has `rsp_data`=0x0010 and `rsp_err`=0.
- **Flags:**
  - Stimulus: after MOV R3,R2 (0xC062), req1 issues 0xAB02 (CMP R3,R2).
  - Required: `rsp1_valid` pulse with `rsp_flags`=3'b001.
- **Fairness:**
  - Stimulus: both valids high from reset with MOV immediates, held for 4 transactions.
  - Required: ready pulses ordered 0,1,0,1; `cpu_load` high for exactly 1 cycle per transaction; `busy` low only between transactions.
- **Timeout:**
  - Stimulus: a cpu stub holds `cpu_w`=1 forever; `TIMEOUT`=8; req0 valid.
  - Required: `rsp0_valid` with `rsp_err`=1 and `rsp_data`=0 exactly 10 cycles after accept; the block then returns to IDLE.
- **Reset mid-operation:**
  - Stimulus: assert `reset` for 1 cycle while in WAIT_DONE.
  - Required: no `rsp_valid`; all outputs at reset values the next cycle; a new req0 is accepted once `cpu_w`=1.
- **cpu not idle:**
  - Stimulus: hold `cpu_w`=0 in IDLE with req0 valid.
  - Required: no ready pulse and `cpu_load`=0 until `cpu_w`=1.

Source files
------------

// File: rtl/cpu_issue_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_issue_arbiter_if
//   Bundles everything that crosses the arbiter boundary: the two instruction
//   requesters, the shared response bus, and the cpu's top-level ports.
//
//   Requester side : req0/1_valid, req0/1_instr  -> arbiter
//                    req0/1_ready, rsp0/1_valid  <- arbiter
//                    rsp_data, rsp_flags {N,V,Z}, rsp_err, busy <- arbiter
//   Cpu side       : cpu_in, cpu_load, cpu_s     <- arbiter
//                    cpu_out, cpu_N/V/Z, cpu_w   -> arbiter
//
//   slave  : the arbiter's view.
//   master : the environment's view (requesters plus the cpu).
// ---------------------------------------------------------------------------
interface cpu_issue_arbiter_if;
   logic        req0_valid;
   logic        req1_valid;
   logic [15:0] req0_instr;
   logic [15:0] req1_instr;
   logic        req0_ready;
   logic        req1_ready;
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_flags;
   logic        rsp_err;
   logic        busy;
   logic [15:0] cpu_in;
   logic        cpu_load;
   logic        cpu_s;
   logic [15:0] cpu_out;
   logic        cpu_N;
   logic        cpu_V;
   logic        cpu_Z;
   logic        cpu_w;

   modport slave (
      input  req0_valid, req1_valid, req0_instr, req1_instr,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      output rsp_data, rsp_flags, rsp_err, busy,
      output cpu_in, cpu_load, cpu_s,
      input  cpu_out, cpu_N, cpu_V, cpu_Z, cpu_w
   );

   modport master (
      output req0_valid, req1_valid, req0_instr, req1_instr,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
      input  rsp_data, rsp_flags, rsp_err, busy,
      input  cpu_in, cpu_load, cpu_s,
      output cpu_out, cpu_N, cpu_V, cpu_Z, cpu_w
   );
endinterface

// File: rtl/cpu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_issue_arbiter
//   Shares one cpu between two instruction requesters. One instruction is in
//   flight at a time; grants are round-robin when both requesters are valid.
//   The instruction is issued with a one-cycle cpu_load/cpu_s pulse, the
//   cpu's w signal is tracked through start and completion, and out/{N,V,Z}
//   are returned to the owning requester with a one-cycle rspN_valid pulse.
//   A watchdog aborts with rsp_err=1 if the cpu fails to finish in time.
//
//   Parameters : TIMEOUT (2..255) cycles allowed in WAIT_START + WAIT_DONE.
//   Ports      : clk   - rising-edge clock
//                reset - synchronous, active-high
//                bus   - cpu_issue_arbiter_if.slave (requesters, response
//                        bus, cpu ports)
// ---------------------------------------------------------------------------
module cpu_issue_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   cpu_issue_arbiter_if.slave    bus
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE,
      RESP
   } state_t;

   localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      state_nxt;
   logic        last;        // previous owner; the other side wins a tie
   logic        owner;       // requester that owns the in-flight instruction
   logic [15:0] instr;       // captured instruction, drives cpu_in directly
   logic [7:0]  wd_cnt;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_flags;
   logic        rsp_err;

   logic        grant_any;
   logic        grant_sel;   // 0: req0, 1: req1
   logic        done_hit;
   logic        timeout_hit;
   logic        cpu_strobe;
   logic        rsp_pulse;

   // -------------------------------------------------------------------------
   // Next-state and decode
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path
      // through the case leaves one unassigned (which would infer a latch).
      state_nxt   = state;
      grant_any   = 1'b0;
      grant_sel   = 1'b0;
      done_hit    = 1'b0;
      timeout_hit = 1'b0;
      cpu_strobe  = 1'b0;
      rsp_pulse   = 1'b0;

      case (state)
         IDLE: begin
            // Only hand work to a cpu that reports itself idle. Grants are
            // suppressed while reset is held so no ready pulse escapes.
            if (!reset && bus.cpu_w && (bus.req0_valid || bus.req1_valid)) begin
               grant_any = 1'b1;
               grant_sel = (bus.req0_valid && bus.req1_valid) ? ~last : bus.req1_valid;
               state_nxt = ISSUE;
            end
         end

         ISSUE: begin
            cpu_strobe = 1'b1;
            state_nxt  = WAIT_START;
         end

         WAIT_START: begin
            if (wd_cnt == WD_LIMIT) begin
               timeout_hit = 1'b1;
               state_nxt   = RESP;
            end else if (!bus.cpu_w) begin
               state_nxt = WAIT_DONE;
            end
         end

         WAIT_DONE: begin
            // Completion wins over a watchdog expiry in the same cycle.
            if (bus.cpu_w) begin
               done_hit  = 1'b1;
               state_nxt = RESP;
            end else if (wd_cnt == WD_LIMIT) begin
               timeout_hit = 1'b1;
               state_nxt   = RESP;
            end
         end

         RESP: begin
            rsp_pulse = 1'b1;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State and datapath registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         owner     <= 1'b0;
         instr     <= '0;
         wd_cnt    <= '0;
         rsp_data  <= '0;
         rsp_flags <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_nxt;

         if (grant_any) begin
            owner <= grant_sel;
            last  <= grant_sel;
            instr <= grant_sel ? bus.req1_instr : bus.req0_instr;
         end

         // Cleared while issuing so it reads 0 on the first WAIT_START cycle.
         if (state == ISSUE) begin
            wd_cnt <= '0;
         end else if (state == WAIT_START || state == WAIT_DONE) begin
            wd_cnt <= wd_cnt + 8'd1;
         end

         if (done_hit) begin
            rsp_data  <= bus.cpu_out;
            rsp_flags <= {bus.cpu_N, bus.cpu_V, bus.cpu_Z};
            rsp_err   <= 1'b0;
         end else if (timeout_hit) begin
            // Flags deliberately keep their last captured value on an abort.
            rsp_data <= '0;
            rsp_err  <= 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign bus.req0_ready = grant_any && !grant_sel;
   assign bus.req1_ready = grant_any &&  grant_sel;
   assign bus.rsp0_valid = rsp_pulse && !owner;
   assign bus.rsp1_valid = rsp_pulse &&  owner;
   assign bus.rsp_data   = rsp_data;
   assign bus.rsp_flags  = rsp_flags;
   assign bus.rsp_err    = rsp_err;
   assign bus.busy       = (state != IDLE);
   assign bus.cpu_in     = instr;
   assign bus.cpu_load   = cpu_strobe;
   assign bus.cpu_s      = cpu_strobe;

endmodule

// File: tb/tb_cpu_issue_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_issue_arbiter
//   Directed bench for cpu_issue_arbiter. A small behavioural cpu stub sits
//   on the main instance (3 busy cycles per instruction, MOV/ADD/CMP
//   subset). A second instance with TIMEOUT=8 sees a cpu whose w never drops.
// ---------------------------------------------------------------------------
module tb_cpu_issue_arbiter;

   localparam int STUB_LAT = 3;

   logic clk = 1'b0;
   logic reset;
   logic cpu_rst;
   logic force_low;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cpu_issue_arbiter_if bus ();
   cpu_issue_arbiter_if bus_t ();

   cpu_issue_arbiter #(.TIMEOUT(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   cpu_issue_arbiter #(.TIMEOUT(8)) dut_t (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_t)
   );

   // ---------------- cpu stub for the main instance ----------------
   logic [15:0] regs [8];
   logic [15:0] ir;
   logic [15:0] c_reg;
   logic [2:0]  nvz;
   logic [3:0]  scnt;
   logic [15:0] sh_val;
   logic [15:0] op_a;
   logic [15:0] sum;
   logic [15:0] diff;

   always_comb begin
      op_a   = regs[ir[10:8]];
      sh_val = regs[ir[2:0]];
      case (ir[4:3])
         2'b01:   sh_val = regs[ir[2:0]] << 1;
         2'b10:   sh_val = regs[ir[2:0]] >> 1;
         2'b11:   sh_val = {regs[ir[2:0]][15], regs[ir[2:0]][15:1]};
         default: sh_val = regs[ir[2:0]];
      endcase
      sum  = op_a + sh_val;
      diff = op_a - sh_val;
   end

   always @(posedge clk) begin
      if (cpu_rst) begin
         scnt  <= '0;
         ir    <= '0;
         c_reg <= '0;
         nvz   <= '0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else if (scnt == 0) begin
         if (bus.cpu_load) ir <= bus.cpu_in;
         if (bus.cpu_s && !force_low) scnt <= 4'(STUB_LAT);
      end else begin
         scnt <= scnt - 4'd1;
         if (scnt == 4'd1) begin
            case (ir[15:13])
               3'b110: begin
                  if (ir[12:11] == 2'b10) begin
                     regs[ir[10:8]] <= {{8{ir[7]}}, ir[7:0]};
                  end else begin
                     regs[ir[7:5]] <= sh_val;
                     c_reg         <= sh_val;
                  end
               end
               3'b101: begin
                  if (ir[12:11] == 2'b00) begin
                     regs[ir[7:5]] <= sum;
                     c_reg         <= sum;
                  end else if (ir[12:11] == 2'b01) begin
                     nvz <= {diff[15],
                             (op_a[15] != sh_val[15]) && (diff[15] != op_a[15]),
                             diff == 16'd0};
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.cpu_w   = (scnt == 4'd0) && !force_low;
   assign bus.cpu_out = c_reg;
   assign bus.cpu_N   = nvz[2];
   assign bus.cpu_V   = nvz[1];
   assign bus.cpu_Z   = nvz[0];

   // Timeout instance: cpu never leaves idle.
   assign bus_t.cpu_w   = 1'b1;
   assign bus_t.cpu_out = 16'h1234;
   assign bus_t.cpu_N   = 1'b1;
   assign bus_t.cpu_V   = 1'b0;
   assign bus_t.cpu_Z   = 1'b1;

   // ---------------- transaction driver (no checks inside) ----------------
   task automatic run_txn(input int who, input logic [15:0] instr,
                          output int owner, output int lat,
                          output logic [15:0] data, output logic [2:0] flags,
                          output logic err, output logic [15:0] issued,
                          output int loads);
      bit acc = 0;
      owner  = -1;
      lat    = -1;
      data   = 'x;
      flags  = 'x;
      err    = 1'bx;
      issued = 'x;
      loads  = 0;
      @(negedge clk);
      if (who == 0) begin bus.req0_valid = 1'b1; bus.req0_instr = instr; end
      else          begin bus.req1_valid = 1'b1; bus.req1_instr = instr; end
      #1;
      for (int i = 0; i < 50; i++) begin
         if ((who == 0 && bus.req0_ready) || (who == 1 && bus.req1_ready)) begin
            acc = 1;
            break;
         end
         @(negedge clk); #1;
      end
      @(negedge clk);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      if (!acc) return;
      #1;
      for (int k = 1; k < 200; k++) begin
         if (bus.cpu_load) begin loads++; issued = bus.cpu_in; end
         if (bus.rsp0_valid || bus.rsp1_valid) begin
            owner = bus.rsp1_valid ? 1 : 0;
            lat   = k;
            data  = bus.rsp_data;
            flags = bus.rsp_flags;
            err   = bus.rsp_err;
            break;
         end
         @(negedge clk); #1;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; cpu_rst = 1'b1; force_low = 1'b0;
      bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_instr = 0; bus.req1_instr = 0;
      bus_t.req0_valid = 0; bus_t.req1_valid = 0; bus_t.req0_instr = 0; bus_t.req1_instr = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0) begin
         failures++; $display("FAIL reset_handshake got=%b exp=0000",
                              {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid}); end
      checks++; if ({bus.cpu_load, bus.cpu_s} !== 2'b00) begin failures++; $display("FAIL reset_load_s got=%b exp=00", {bus.cpu_load, bus.cpu_s}); end
      checks++; if (bus.cpu_in !== 16'h0) begin failures++; $display("FAIL reset_cpu_in got=%h exp=0000", bus.cpu_in); end
      checks++; if ({bus.rsp_data, bus.rsp_flags, bus.rsp_err} !== 20'h0) begin
         failures++; $display("FAIL reset_rsp got=%h/%b/%b exp=0", bus.rsp_data, bus.rsp_flags, bus.rsp_err); end
      checks++; if (bus_t.busy !== 1'b0) begin failures++; $display("FAIL reset_busy_t got=%b exp=0", bus_t.busy); end
      @(negedge clk);
      reset = 1'b0; cpu_rst = 1'b0;
   endtask

   task automatic test_basic();
      int owner, lat, loads; logic [15:0] data, issued; logic [2:0] flags; logic err;
      run_txn(0, 16'hD007, owner, lat, data, flags, err, issued, loads);
      checks++; if (owner !== 0) begin failures++; $display("FAIL basic1_owner got=%0d exp=0", owner); end
      checks++; if (lat !== 6) begin failures++; $display("FAIL basic1_latency got=%0d exp=6", lat); end
      checks++; if (loads !== 1 || issued !== 16'hD007) begin
         failures++; $display("FAIL basic1_issue got=%0d/%h exp=1/d007", loads, issued); end
      run_txn(1, 16'hD102, owner, lat, data, flags, err, issued, loads);
      checks++; if (owner !== 1) begin failures++; $display("FAIL basic2_owner got=%0d exp=1", owner); end
      run_txn(0, 16'hA148, owner, lat, data, flags, err, issued, loads);
      checks++; if (owner !== 0) begin failures++; $display("FAIL basic3_owner got=%0d exp=0", owner); end
      checks++; if (data !== 16'h0010) begin failures++; $display("FAIL basic3_data got=%h exp=0010", data); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic3_err got=%b exp=0", err); end
   endtask

   task automatic test_flags();
      int owner, lat, loads; logic [15:0] data, issued; logic [2:0] flags; logic err;
      run_txn(0, 16'hC062, owner, lat, data, flags, err, issued, loads);
      checks++; if (data !== 16'h0010) begin failures++; $display("FAIL flags_mov_data got=%h exp=0010", data); end
      run_txn(1, 16'hAB02, owner, lat, data, flags, err, issued, loads);
      checks++; if (owner !== 1) begin failures++; $display("FAIL flags_owner got=%0d exp=1", owner); end
      checks++; if (flags !== 3'b001) begin failures++; $display("FAIL flags_nvz got=%b exp=001", flags); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL flags_err got=%b exp=0", err); end
   endtask

   task automatic test_fairness();
      int order [4] = '{-1, -1, -1, -1};
      int g = 0, loads = 0, idle_gap = 0, rsp_seen = 0;
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_instr = 16'hD001;
      bus.req1_valid = 1'b1; bus.req1_instr = 16'hD205;
      #1;
      for (int c = 0; c < 200; c++) begin
         if (c > 0) begin @(negedge clk); #1; end
         if (bus.cpu_load) loads++;
         if (!bus.busy && !(bus.req0_ready || bus.req1_ready)) idle_gap++;
         if (bus.req0_ready && bus.req1_ready) idle_gap++;
         if (bus.req0_ready) begin order[g] = 0; g++; end
         else if (bus.req1_ready) begin order[g] = 1; g++; end
         if (g == 4) break;
      end
      @(negedge clk);
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      #1;
      for (int c = 0; c < 50; c++) begin
         if (bus.cpu_load) loads++;
         if (bus.rsp0_valid || bus.rsp1_valid) begin rsp_seen = 1; break; end
         @(negedge clk); #1;
      end
      checks++; if (order[0] !== 0 || order[1] !== 1 || order[2] !== 0 || order[3] !== 1) begin
         failures++; $display("FAIL fair_order got=%0d,%0d,%0d,%0d exp=0,1,0,1", order[0], order[1], order[2], order[3]); end
      checks++; if (loads !== 4) begin failures++; $display("FAIL fair_loads got=%0d exp=4", loads); end
      checks++; if (idle_gap !== 0) begin failures++; $display("FAIL fair_idle_gaps got=%0d exp=0", idle_gap); end
      checks++; if (rsp_seen !== 1) begin failures++; $display("FAIL fair_last_rsp got=%0d exp=1", rsp_seen); end
      @(negedge clk); #1;
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL fair_idle_after got=%b exp=0", bus.busy); end
   endtask

   task automatic test_timeout();
      int lat = -1;
      logic acc;
      @(negedge clk);
      bus_t.req0_valid = 1'b1; bus_t.req0_instr = 16'hD0FF;
      #1;
      acc = bus_t.req0_ready;
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL tmo_accept got=%b exp=1", acc); end
      @(negedge clk);
      bus_t.req0_valid = 1'b0;
      #1;
      for (int k = 1; k < 40; k++) begin
         if (bus_t.rsp0_valid || bus_t.rsp1_valid) begin lat = k; break; end
         @(negedge clk); #1;
      end
      checks++; if (lat !== 10) begin failures++; $display("FAIL tmo_latency got=%0d exp=10", lat); end
      checks++; if (bus_t.rsp0_valid !== 1'b1 || bus_t.rsp_err !== 1'b1) begin
         failures++; $display("FAIL tmo_rsp got=%b/%b exp=1/1", bus_t.rsp0_valid, bus_t.rsp_err); end
      checks++; if (bus_t.rsp_data !== 16'h0 || bus_t.rsp_flags !== 3'b000) begin
         failures++; $display("FAIL tmo_data_flags got=%h/%b exp=0000/000", bus_t.rsp_data, bus_t.rsp_flags); end
      @(negedge clk); #1;
      checks++; if (bus_t.busy !== 1'b0) begin failures++; $display("FAIL tmo_back_idle got=%b exp=0", bus_t.busy); end
   endtask

   task automatic test_reset_mid_op();
      int stray = 0, done = 0;
      logic r4, r5;
      @(negedge clk);
      bus.req0_valid = 1'b1; bus.req0_instr = 16'hD00A;
      #1;
      checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL rmid_accept got=%b exp=1", bus.req0_ready); end
      @(negedge clk); bus.req0_valid = 1'b0;       // ISSUE
      @(negedge clk);                              // WAIT_START
      @(negedge clk); #1;                          // WAIT_DONE
      checks++; if (bus.busy !== 1'b1 || bus.cpu_w !== 1'b0) begin
         failures++; $display("FAIL rmid_in_flight got=%b/%b exp=1/0", bus.busy, bus.cpu_w); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_instr = 16'hD10B;
      #1;
      if (bus.rsp0_valid || bus.rsp1_valid) stray++;
      r4 = bus.req0_ready;
      checks++; if ({bus.busy, bus.cpu_load, bus.cpu_s, bus.rsp_err} !== 4'b0 || bus.cpu_in !== 16'h0) begin
         failures++; $display("FAIL rmid_reset_vals got=%b%b%b%b/%h exp=0000/0000",
                              bus.busy, bus.cpu_load, bus.cpu_s, bus.rsp_err, bus.cpu_in); end
      checks++; if (bus.rsp_data !== 16'h0 || bus.rsp_flags !== 3'b0) begin
         failures++; $display("FAIL rmid_rsp_vals got=%h/%b exp=0000/000", bus.rsp_data, bus.rsp_flags); end
      checks++; if (r4 !== 1'b0) begin failures++; $display("FAIL rmid_no_accept_busy_cpu got=%b exp=0", r4); end
      @(negedge clk); #1;
      if (bus.rsp0_valid || bus.rsp1_valid) stray++;
      r5 = bus.req0_ready;
      checks++; if (r5 !== 1'b1) begin failures++; $display("FAIL rmid_accept_after got=%b exp=1", r5); end
      checks++; if (stray !== 0) begin failures++; $display("FAIL rmid_stray_rsp got=%0d exp=0", stray); end
      @(negedge clk); bus.req0_valid = 1'b0; #1;
      for (int k = 0; k < 50; k++) begin
         if (bus.rsp0_valid) begin done = 1; break; end
         @(negedge clk); #1;
      end
      checks++; if (done !== 1) begin failures++; $display("FAIL rmid_new_rsp got=%0d exp=1", done); end
   endtask

   task automatic test_cpu_not_idle();
      int viol = 0, done = 0;
      @(negedge clk);
      force_low = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_instr = 16'hD203;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (bus.req0_ready || bus.cpu_load) viol++;
         @(negedge clk);
      end
      checks++; if (viol !== 0) begin failures++; $display("FAIL nidle_held_off got=%0d exp=0", viol); end
      force_low = 1'b0;
      #1;
      checks++; if (bus.req0_ready !== 1'b1) begin failures++; $display("FAIL nidle_accept got=%b exp=1", bus.req0_ready); end
      @(negedge clk); bus.req0_valid = 1'b0; #1;
      for (int k = 0; k < 50; k++) begin
         if (bus.rsp0_valid) begin done = 1; break; end
         @(negedge clk); #1;
      end
      checks++; if (done !== 1) begin failures++; $display("FAIL nidle_rsp got=%0d exp=1", done); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_flags();
      test_fairness();
      test_timeout();
      test_reset_mid_op();
      test_cpu_not_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench did not finish");
   end

endmodule
